// File: rtl/cyq_cmp_pkg.sv
// Shared types and encodings for the cyq_seq_cmp multi-cycle comparator.
// Contents: FSM state enum, MODE encodings, one-hot {GT,EQ,LT} result codes,
// and a helper that replaces a non-one-hot cascade input with EQ.
package cyq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UNS = 2'b00;
    localparam logic [1:0] MODE_SM  = 2'b01;
    localparam logic [1:0] MODE_TC  = 2'b10;

    localparam logic [2:0] Q_GT = 3'b100;
    localparam logic [2:0] Q_EQ = 3'b010;
    localparam logic [2:0] Q_LT = 3'b001;

    // Any cascade input that is not exactly one-hot is read as "equal".
    function automatic logic [2:0] cas_norm(input logic [2:0] cas);
        case (cas)
            Q_GT, Q_EQ, Q_LT: cas_norm = cas;
            default:          cas_norm = Q_EQ;
        endcase
    endfunction

endpackage

// File: rtl/cyq_key_conv.sv
// Combinational number-format to offset-binary key converter.
// Ports:
//   op    in  WIDTH  operand
//   mode  in  2      00 unsigned, 01 sign-magnitude, 10 two's complement, 11 as 00
//   key_c out WIDTH  key whose unsigned order matches the operand's signed order
module cyq_key_conv
    import cyq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] op,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] key_c
);

    // Sign-magnitude: negatives map below 1000..0 with magnitude order
    // reversed; a zero magnitude with either sign maps to +0.
    always_comb begin
        key_c = op;
        case (mode)
            MODE_TC: key_c = {~op[WIDTH-1], op[WIDTH-2:0]};
            MODE_SM: begin
                if (!op[WIDTH-1] || (op[WIDTH-2:0] == '0)) begin
                    key_c = {1'b1, op[WIDTH-2:0]};
                end else begin
                    key_c = {1'b0, ~op[WIDTH-2:0]};
                end
            end
            default: key_c = op;
        endcase
    end

endmodule

// File: rtl/cyq_seq_cmp.sv
// Multi-cycle magnitude comparator, SLICE key bits per cycle, MSB first.
// Ports:
//   CLK, RSTN (async, active-low)
//   A, B       in  WIDTH  operands, sampled on accept
//   MODE       in  2      number format (see cyq_key_conv)
//   CAS_I      in  3      {GT,EQ,LT} cascade input used when all slices match
//   IN_VALID   in  / IN_READY  out   operand handshake (ready only in IDLE)
//   Q          out 3      one-hot {A>B, A=B, A<B}
//   OUT_VALID  out / OUT_READY in    result handshake
// Build option: define CYQ_CMP_EARLY_EXIT_EN to stop at the first differing
// slice; otherwise every comparison takes all NSLICE cycles.
module cyq_seq_cmp
    import cyq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       MODE,
    input  logic [2:0]       CAS_I,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [2:0]       Q,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  key_a_q, key_a_d;
    logic [WIDTH-1:0]  key_b_q, key_b_d;
    logic [2:0]        cas_q, cas_d;
    logic [2:0]        q_q, q_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
`ifndef CYQ_CMP_EARLY_EXIT_EN
    logic              decided_q, decided_d;
    logic [2:0]        pend_q, pend_d;
`endif

    logic [WIDTH-1:0]  key_a_c, key_b_c;
    logic [SLICE-1:0]  slice_a_c, slice_b_c;
    logic              slice_gt_c, slice_lt_c;
    logic              accept_c;

    cyq_key_conv #(.WIDTH(WIDTH)) u_conv_a (.op(A), .mode(MODE), .key_c(key_a_c));
    cyq_key_conv #(.WIDTH(WIDTH)) u_conv_b (.op(B), .mode(MODE), .key_c(key_b_c));

    // Keys are shifted left each CMP cycle, so the current slice is always on top.
    assign slice_a_c  = key_a_q[WIDTH-1 -: SLICE];
    assign slice_b_c  = key_b_q[WIDTH-1 -: SLICE];
    assign slice_gt_c = (slice_a_c > slice_b_c);
    assign slice_lt_c = (slice_a_c < slice_b_c);
    assign accept_c   = IN_VALID && in_ready_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        key_a_d   = key_a_q;
        key_b_d   = key_b_q;
        cas_d     = cas_q;
        q_d       = q_q;
`ifndef CYQ_CMP_EARLY_EXIT_EN
        decided_d = decided_q;
        pend_d    = pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    key_a_d = key_a_c;
                    key_b_d = key_b_c;
                    cas_d   = cas_norm(CAS_I);
                    k_d     = K_LAST;
                    state_d = CMP;
`ifndef CYQ_CMP_EARLY_EXIT_EN
                    decided_d = 1'b0;
                    pend_d    = Q_EQ;
`endif
                end
            end
            CMP: begin
                key_a_d = key_a_q << SLICE;
                key_b_d = key_b_q << SLICE;
                k_d     = k_q - KW'(1);
`ifdef CYQ_CMP_EARLY_EXIT_EN
                if (slice_gt_c || slice_lt_c) begin
                    q_d     = slice_gt_c ? Q_GT : Q_LT;
                    state_d = DONE;
                end else if (k_q == '0) begin
                    q_d     = cas_q;
                    state_d = DONE;
                end
`else
                // First differing slice wins; later slices only run out the clock.
                if (!decided_q && (slice_gt_c || slice_lt_c)) begin
                    decided_d = 1'b1;
                    pend_d    = slice_gt_c ? Q_GT : Q_LT;
                end
                if (k_q == '0) begin
                    state_d = DONE;
                    if (decided_q) begin
                        q_d = pend_q;
                    end else if (slice_gt_c) begin
                        q_d = Q_GT;
                    end else if (slice_lt_c) begin
                        q_d = Q_LT;
                    end else begin
                        q_d = cas_q;
                    end
                end
`endif
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            k_q         <= '0;
            key_a_q     <= '0;
            key_b_q     <= '0;
            cas_q       <= Q_EQ;
            q_q         <= Q_EQ;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifndef CYQ_CMP_EARLY_EXIT_EN
            decided_q   <= 1'b0;
            pend_q      <= Q_EQ;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            key_a_q     <= key_a_d;
            key_b_q     <= key_b_d;
            cas_q       <= cas_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifndef CYQ_CMP_EARLY_EXIT_EN
            decided_q   <= decided_d;
            pend_q      <= pend_d;
`endif
        end
    end

    assign IN_READY  = in_ready_q;
    assign Q         = q_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_cyq_seq_cmp.sv
// Directed, table-driven bench for cyq_seq_cmp (WIDTH=16, SLICE=4).
// Honours CYQ_CMP_EARLY_EXIT_EN for the expected latency.
module tb_cyq_seq_cmp;

    localparam int NSL = 4;

    logic        CLK;
    logic        RSTN;
    logic [15:0] A, B;
    logic [1:0]  MODE;
    logic [2:0]  CAS_I;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  Q;
    logic        OUT_VALID;
    logic        OUT_READY;

    int n_checks = 0;
    int n_errors = 0;

    cyq_seq_cmp #(.WIDTH(16), .SLICE(4)) dut (
        .CLK(CLK), .RSTN(RSTN), .A(A), .B(B), .MODE(MODE), .CAS_I(CAS_I),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Q(Q),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  mode;
        logic [2:0]  cas;
        logic [2:0]  q;
        int          j;    // 1-based position of first differing slice (NSL if none)
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int j);
`ifdef CYQ_CMP_EARLY_EXIT_EN
        return 1 + j;
`else
        if (j > 0) return 1 + NSL;
        return 1 + NSL;
`endif
    endfunction

    // Wait for OUT_VALID, bounded; returns latency in cycles counted from the accept cycle.
    task automatic wait_result(output int lat);
        int edges;
        edges = 0;
        while (!OUT_VALID && edges < 20) begin
            @(posedge CLK); #1;
            edges++;
        end
        lat = edges + 1;
    endtask

    // Present operands in IDLE and clock the accept edge.
    task automatic accept(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] mode, input logic [2:0] cas);
        A = a; B = b; MODE = mode; CAS_I = cas; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        // Operands may change after accept without affecting the result.
        A = 16'(~a); B = 16'(~b); MODE = 2'(mode + 2'd1); CAS_I = 3'b111;
    endtask

    task automatic handshake();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    logic [2:0] q_hold;
    int         lat;
    int         pulses;

    initial begin
        vecs[0]  = '{16'h8005, 16'h0003, 2'b01, 3'b010, 3'b001, 1};
        vecs[1]  = '{16'h8000, 16'h0000, 2'b01, 3'b010, 3'b010, NSL};
        vecs[2]  = '{16'hFFFF, 16'h0001, 2'b10, 3'b010, 3'b001, 1};
        vecs[3]  = '{16'hFFFF, 16'h0001, 2'b00, 3'b010, 3'b100, 1};
        vecs[4]  = '{16'hFFFF, 16'h0001, 2'b11, 3'b010, 3'b100, 1};
        vecs[5]  = '{16'h1234, 16'h1234, 2'b00, 3'b100, 3'b100, NSL};
        vecs[6]  = '{16'h1234, 16'h1234, 2'b00, 3'b011, 3'b010, NSL};
        vecs[7]  = '{16'h1234, 16'h1235, 2'b00, 3'b010, 3'b001, NSL};
        vecs[8]  = '{16'h1A00, 16'h1900, 2'b00, 3'b010, 3'b100, 2};
        vecs[9]  = '{16'hFFFF, 16'h0001, 2'b01, 3'b010, 3'b001, 1};
        vecs[10] = '{16'h8000, 16'h7FFF, 2'b10, 3'b100, 3'b001, 1};
        vecs[11] = '{16'h1A00, 16'h19FF, 2'b00, 3'b001, 3'b100, 2};
        vecs[12] = '{16'h00C3, 16'h00C3, 2'b00, 3'b000, 3'b010, NSL};

        RSTN = 1'b0; A = '0; B = '0; MODE = '0; CAS_I = '0;
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        #12;
        check("reset_q", 32'(Q), 32'(3'b010));
        check("reset_out_valid", 32'(OUT_VALID), 0);
        check("reset_in_ready", 32'(IN_READY), 1);
        RSTN = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 13; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].cas);
            check($sformatf("v%0d_busy_in_ready", i), 32'(IN_READY), 0);
            wait_result(lat);
            check($sformatf("v%0d_q", i), 32'(Q), 32'(vecs[i].q));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].j)));
            handshake();
            check($sformatf("v%0d_q_hold_idle", i), 32'(Q), 32'(vecs[i].q));
            check($sformatf("v%0d_idle_out_valid", i), 32'(OUT_VALID), 0);
            check($sformatf("v%0d_idle_in_ready", i), 32'(IN_READY), 1);
        end

        // Backpressure: hold DONE for 3 cycles, then back-to-back accept.
        accept(16'h1A00, 16'h19FF, 2'b00, 3'b010);
        wait_result(lat);
        check("bp_q", 32'(Q), 32'(3'b100));
        q_hold = Q;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            check($sformatf("bp_hold%0d_q", c), 32'(Q), 32'(q_hold));
            check($sformatf("bp_hold%0d_out_valid", c), 32'(OUT_VALID), 1);
            check($sformatf("bp_hold%0d_in_ready", c), 32'(IN_READY), 0);
        end
        handshake();
        check("bp_release_in_ready", 32'(IN_READY), 1);
        check("bp_release_out_valid", 32'(OUT_VALID), 0);
        accept(16'h0003, 16'h8005, 2'b01, 3'b010);
        check("b2b_accepted", 32'(IN_READY), 0);
        wait_result(lat);
        check("b2b_q", 32'(Q), 32'(3'b100));
        check("b2b_latency", 32'(lat), 32'(exp_lat(1)));
        handshake();

        // Reset abort during CMP: equal keys with CAS GT would otherwise give 100.
        accept(16'h5555, 16'h5555, 2'b00, 3'b100);
        @(posedge CLK);
        #3 RSTN = 1'b0;
        #1;
        check("abort_out_valid", 32'(OUT_VALID), 0);
        check("abort_q", 32'(Q), 32'(3'b010));
        check("abort_in_ready", 32'(IN_READY), 1);
        @(negedge CLK);
        RSTN = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 0);
        check("abort_q_after", 32'(Q), 32'(3'b010));
        check("abort_in_ready_after", 32'(IN_READY), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
